// File: rtl/laser_dual_cover.sv
// laser_dual_cover
//   Two-laser coverage engine. A frame of N_PTS points on a
//   2^COORD_W x 2^COORD_W grid is loaded. The engine then searches for two
//   circle centres of radius RADIUS that cover as many points as possible.
//
//   Search order:
//   - SWEEP1 sweeps C1 alone.
//   - After that, each pass fixes one centre and re-sweeps the other:
//     SWEEP2 moves C2, SWEEPA moves C1, and the two alternate.
//   - Each candidate takes N_PTS evaluation cycles, one point per cycle,
//     followed by one compare cycle.
//
//   Optional feature, macro LASER_EARLY_STOP_EN: when defined, the search ends
//   after the first refinement pass that brings no strict improvement.
//   Without it, exactly MAX_PASS refinement passes always run.
//
// Handshake: a point is taken on a rising CLK edge where IN_VALID and
//   IN_READY are both high. IN_READY is high only in LOAD. IN_VALID is
//   ignored in every other state.
//
// Ports:
//   CLK, RST            clock (rising edge), asynchronous active-high reset
//   IN_VALID, X, Y      point stream input
//   IN_READY            high while the engine is loading a frame
//   C1X, C1Y, C2X, C2Y  best centres, updated in the DONE cycle and then held
//   COVER               number of points covered by the union of C1 and C2
//   DONE                one-cycle result strobe
//   o_dbg_state         current FSM state: 0 LOAD, 1 SWEEP1, 2 SWEEP2,
//                       3 SWEEPA, 4 FINISH
module laser_dual_cover #(
  parameter int N_PTS    = 40,
  parameter int COORD_W  = 4,
  parameter int RADIUS   = 4,
  parameter int MAX_PASS = 4,
  localparam int CNT_W   = $clog2(N_PTS + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  output logic               IN_READY,
  output logic [COORD_W-1:0] C1X,
  output logic [COORD_W-1:0] C1Y,
  output logic [COORD_W-1:0] C2X,
  output logic [COORD_W-1:0] C2Y,
  output logic [CNT_W-1:0]   COVER,
  output logic               DONE,
  output logic [2:0]         o_dbg_state
);

  localparam int PI_W   = (N_PTS > 1) ? $clog2(N_PTS) : 1;
  localparam int PASS_W = $clog2(MAX_PASS + 1);
  localparam int SQ_W   = 2 * COORD_W;
  localparam int SUM_W  = 2 * COORD_W + 1;
  localparam int unsigned R2 = RADIUS * RADIUS;
  localparam logic [COORD_W-1:0] MAXC = '1;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_SWEEP1 = 3'd1,
    S_SWEEP2 = 3'd2,
    S_SWEEPA = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [COORD_W-1:0] r_px [N_PTS];
  logic [COORD_W-1:0] r_py [N_PTS];
  logic [CNT_W-1:0]   r_ld_cnt, r_idx, r_cnt, r_best_cnt, r_out_cover;
  logic [COORD_W-1:0] r_cand_x, r_cand_y;
  logic [COORD_W-1:0] r_best_c1x, r_best_c1y, r_best_c2x, r_best_c2y;
  logic [COORD_W-1:0] r_out_c1x, r_out_c1y, r_out_c2x, r_out_c2y;
  logic [PASS_W-1:0]  r_pass;
  logic               r_improved;

  logic               w_in_sweep, w_accept, w_load_done, w_cmp, w_better;
  logic               w_sweep_end, w_stop, w_hit;
  logic [COORD_W-1:0] w_px, w_py, w_fx, w_fy;

  // Exact squared distance test. Nothing is truncated, so the edge case
  // dist^2 == RADIUS^2 counts as inside.
  function automatic logic f_inside(input logic [COORD_W-1:0] px, py, cx, cy);
    logic [COORD_W-1:0] dx, dy;
    logic [SQ_W-1:0]    ex, ey;
    logic [SUM_W-1:0]   s;
    dx = (px >= cx) ? px - cx : cx - px;
    dy = (py >= cy) ? py - cy : cy - py;
    ex = {{COORD_W{1'b0}}, dx};
    ey = {{COORD_W{1'b0}}, dy};
    s  = {1'b0, ex * ex} + {1'b0, ey * ey};
    return (32'(s) <= R2);
  endfunction

  assign w_in_sweep  = (r_state == S_SWEEP1) || (r_state == S_SWEEP2) ||
                       (r_state == S_SWEEPA);
  assign w_accept    = IN_VALID && (r_state == S_LOAD);
  assign w_load_done = w_accept && (r_ld_cnt == CNT_W'(N_PTS - 1));
  // r_idx == N_PTS marks the compare cycle that follows the N_PTS point cycles.
  assign w_cmp       = w_in_sweep && (r_idx == CNT_W'(N_PTS));
  assign w_better    = w_cmp && (r_cnt > r_best_cnt);
  assign w_sweep_end = w_cmp && (r_cand_x == MAXC) && (r_cand_y == MAXC);

  // The improvement found in the final compare cycle of a pass must count
  // too, because r_improved only registers it on that same edge.
`ifdef LASER_EARLY_STOP_EN
  assign w_stop = (r_pass == PASS_W'(MAX_PASS)) || !(r_improved || w_better);
`else
  assign w_stop = (r_pass == PASS_W'(MAX_PASS));
`endif

  // The compare cycle may read one slot beyond the frame. That value is unused.
  assign w_px = r_px[r_idx[PI_W-1:0]];
  assign w_py = r_py[r_idx[PI_W-1:0]];
  // The fixed centre is C2 while C1 is re-swept, and C1 otherwise.
  assign w_fx = (r_state == S_SWEEPA) ? r_best_c2x : r_best_c1x;
  assign w_fy = (r_state == S_SWEEPA) ? r_best_c2y : r_best_c1y;
  // SWEEP1 counts single-circle hits. The refinement passes count the union.
  assign w_hit = f_inside(w_px, w_py, r_cand_x, r_cand_y) ||
                 ((r_state != S_SWEEP1) && f_inside(w_px, w_py, w_fx, w_fy));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_LOAD;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    IN_READY    = (r_state == S_LOAD);
    DONE        = (r_state == S_FINISH);
    C1X         = r_out_c1x;
    C1Y         = r_out_c1y;
    C2X         = r_out_c2x;
    C2Y         = r_out_c2y;
    COVER       = r_out_cover;
    o_dbg_state = r_state;
    case (r_state)
      S_LOAD:   if (w_load_done) w_next = S_SWEEP1;
      S_SWEEP1: if (w_sweep_end) w_next = S_SWEEP2;
      S_SWEEP2: if (w_sweep_end) w_next = w_stop ? S_FINISH : S_SWEEPA;
      S_SWEEPA: if (w_sweep_end) w_next = w_stop ? S_FINISH : S_SWEEP2;
      S_FINISH: begin
        w_next = S_LOAD;
        // The result is shown directly from the best registers in the DONE
        // cycle, because the last compare may have updated them on the
        // edge that entered FINISH.
        C1X    = r_best_c1x;
        C1Y    = r_best_c1y;
        C2X    = r_best_c2x;
        C2Y    = r_best_c2y;
        COVER  = r_best_cnt;
      end
      default:  w_next = S_LOAD;
    endcase
  end

  // The point buffer has no reset. A new frame always overwrites every slot.
  always_ff @(posedge CLK) begin
    if (w_accept) begin
      r_px[r_ld_cnt[PI_W-1:0]] <= X;
      r_py[r_ld_cnt[PI_W-1:0]] <= Y;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_ld_cnt    <= '0;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_best_cnt  <= '0;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_best_c1x  <= '0;
      r_best_c1y  <= '0;
      r_best_c2x  <= '0;
      r_best_c2y  <= '0;
      r_out_c1x   <= '0;
      r_out_c1y   <= '0;
      r_out_c2x   <= '0;
      r_out_c2y   <= '0;
      r_out_cover <= '0;
      r_pass      <= '0;
      r_improved  <= 1'b0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (w_accept) r_ld_cnt <= r_ld_cnt + 1'b1;
          if (w_load_done) begin
            // Entering SWEEP1. Clear the best result and restart the raster.
            r_ld_cnt   <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_best_cnt <= '0;
            r_best_c1x <= '0;
            r_best_c1y <= '0;
            r_best_c2x <= '0;
            r_best_c2y <= '0;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_pass     <= '0;
            r_improved <= 1'b0;
          end
        end
        S_SWEEP1, S_SWEEP2, S_SWEEPA: begin
          if (!w_cmp) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, w_hit};
            r_idx <= r_idx + 1'b1;
          end else begin
            r_idx <= '0;
            r_cnt <= '0;
            if (w_better) begin
              r_best_cnt <= r_cnt;
              r_improved <= 1'b1;
              if (r_state == S_SWEEP2) begin
                r_best_c2x <= r_cand_x;
                r_best_c2y <= r_cand_y;
              end else begin
                r_best_c1x <= r_cand_x;
                r_best_c1y <= r_cand_y;
              end
            end
            // Raster step: x is the inner index. (max,max) wraps back to (0,0),
            // which is the starting point of the next sweep.
            if (r_cand_x == MAXC) begin
              r_cand_x <= '0;
              r_cand_y <= r_cand_y + 1'b1;
            end else begin
              r_cand_x <= r_cand_x + 1'b1;
            end
            if (w_sweep_end) begin
              r_pass     <= r_pass + 1'b1;
              r_improved <= 1'b0;
            end
          end
        end
        S_FINISH: begin
          r_out_c1x   <= r_best_c1x;
          r_out_c1y   <= r_best_c1y;
          r_out_c2x   <= r_best_c2x;
          r_out_c2y   <= r_best_c2y;
          r_out_cover <= r_best_cnt;
        end
        default: ;
      endcase
    end
  end

endmodule
